// File: rtl/gate_response_checker.sv
// gate_response_checker
//   On-chip stimulus/response checker for a 2-input AND/NAND gate under test.
//   Applies {A,B} = 00,01,10,11 in order, waits SETTLE_CYCLES after each
//   vector, samples the gate outputs and accumulates a per-vector failure
//   map, a mismatch count and a pass verdict.
//   Optional feature: define GATE_CHK_LOG_EN to add the obs_log output,
//   which records the raw {obs_and, obs_nand} pair seen for each vector.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SETTLE_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       obs_and,
  input  logic       obs_nand,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
`ifdef GATE_CHK_LOG_EN
  ,
  output logic [7:0] obs_log
`endif
);

  // A settle time of zero would skip sampling entirely, so it is promoted to 1.
  localparam logic [SETTLE_W-1:0] LP_SETTLE =
    (SETTLE_CYCLES == 0) ? SETTLE_W'(1) : SETTLE_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_idx;
  logic [SETTLE_W-1:0] r_cnt;
  logic                r_drv_a;
  logic                r_drv_b;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [2:0]          r_err_count;
  logic [3:0]          r_fail_vec;
`ifdef GATE_CHK_LOG_EN
  logic [7:0]          r_obs_log;
`endif

  logic w_exp_and;
  logic w_mismatch;
  logic w_start_ok;

  // Error counter never exceeds the number of vectors in a run.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'd4) ? v : v + 3'd1;
  endfunction

  // Expected response comes from the registered stimulus, so the compare
  // only ever feeds registers and never reaches an output combinationally.
  assign w_exp_and  = r_drv_a & r_drv_b;
  assign w_mismatch = (obs_and != w_exp_and) | (obs_nand != ~w_exp_and);

  // A new run may begin from IDLE, or from DONE once its results are
  // published (the first DONE cycle is still finalising the verdict).
  assign w_start_ok = start &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && r_done));

  // Sequencer: drive, settle, sample for each vector, then publish a verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_drv_a     <= 1'b0;
      r_drv_b     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 4'd0;
`ifdef GATE_CHK_LOG_EN
      r_obs_log   <= 8'd0;
`endif
    end else if (w_start_ok) begin
      r_state     <= S_DRIVE;
      r_idx       <= 2'd0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 4'd0;
`ifdef GATE_CHK_LOG_EN
      r_obs_log   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end

        S_DRIVE: begin
          r_drv_a <= r_idx[1];
          r_drv_b <= r_idx[0];
          r_cnt   <= LP_SETTLE;
          r_state <= S_SETTLE;
        end

        S_SETTLE: begin
          r_cnt <= r_cnt - SETTLE_W'(1);
          if (r_cnt <= SETTLE_W'(1)) begin
            r_state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          // A vector is counted once even when both outputs are wrong.
          if (w_mismatch) begin
            r_fail_vec[r_idx] <= 1'b1;
            r_err_count       <= sat_inc(r_err_count);
          end
`ifdef GATE_CHK_LOG_EN
          r_obs_log[{r_idx, 1'b0} +: 2] <= {obs_and, obs_nand};
`endif
          if (r_idx == 2'd3) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_DRIVE;
          end
        end

        S_DONE: begin
          // The last sample's count lands on the SAMPLE edge, so the verdict
          // is taken one cycle later from the final count.
          if (!r_done) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_pass <= (r_err_count == 3'd0);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drv_a     = r_drv_a;
  assign drv_b     = r_drv_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;
`ifdef GATE_CHK_LOG_EN
  assign obs_log   = r_obs_log;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker: two instances (settle 1 and settle 3)
// share start/reset and each watches its own behavioural gate model, whose
// fault mode is selected per test vector.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] mode = 3'd0;

  always #5 clk = ~clk;

  logic       drv_a1, drv_b1, obs_and1, obs_nand1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fail1;
  logic       drv_a3, drv_b3, obs_and3, obs_nand3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [3:0] fail3;
`ifdef GATE_CHK_LOG_EN
  logic [7:0] log1, log3;
`endif

  gate_response_checker #(.SETTLE_CYCLES(1), .SETTLE_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .drv_a(drv_a1), .drv_b(drv_b1), .obs_and(obs_and1), .obs_nand(obs_nand1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
`ifdef GATE_CHK_LOG_EN
    , .obs_log(log1)
`endif
  );

  gate_response_checker #(.SETTLE_CYCLES(3), .SETTLE_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .drv_a(drv_a3), .drv_b(drv_b3), .obs_and(obs_and3), .obs_nand(obs_nand3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fail3)
`ifdef GATE_CHK_LOG_EN
    , .obs_log(log3)
`endif
  );

  // Two-cycle delayed AND response for the slow-gate fault mode.
  logic d1_1 = 1'b0, d2_1 = 1'b0, d1_3 = 1'b0, d2_3 = 1'b0;
  always @(posedge clk) begin
    d1_1 <= drv_a1 & drv_b1;
    d2_1 <= d1_1;
    d1_3 <= drv_a3 & drv_b3;
    d2_3 <= d1_3;
  end

  // Gate model: returns {and, nand} for the selected fault mode.
  function automatic logic [1:0] gate(input logic [2:0] m, input logic a,
                                      input logic b, input logic dly);
    logic y;
    y = a & b;
    case (m)
      3'd0:    return {y, ~y};         // ideal
      3'd1:    return {1'b1, ~y};      // AND stuck at 1
      3'd2:    return {~y, y};         // outputs swapped
      3'd3:    return {dly, ~dly};     // 2-cycle delayed gate
      3'd4:    return {y, 1'b0};       // NAND stuck at 0
      3'd5:    return {1'b0, ~y};      // AND stuck at 0
      3'd6:    return {1'b1, 1'b1};    // both stuck at 1
      default: return {1'b0, 1'b1};    // both stuck at idle values
    endcase
  endfunction

  assign {obs_and1, obs_nand1} = gate(mode, drv_a1, drv_b1, d2_1);
  assign {obs_and3, obs_nand3} = gate(mode, drv_a3, drv_b3, d2_3);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pulse start for one edge, then watch up to 40 edges; t1/t3 give the
  // edge count (after the start edge) at which each done first rises.
  // pulse_at > 0 re-asserts start for one edge in the middle of the run.
  task automatic run(input int pulse_at, output int t1, output int t3,
                     output logic [2:0] st1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t1 = 0; t3 = 0; st1 = 3'b000;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at);
      if (c == 1) st1 = {busy1, done1, pass1};
      if (done1 && t1 == 0) t1 = c;
      if (done3 && t3 == 0) t3 = c;
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_zero1"}, 16'({drv_a1, drv_b1, busy1, done1, pass1, err1, fail1}), 16'd0);
    chk({nm, "_zero3"}, 16'({drv_a3, drv_b3, busy3, done3, pass3, err3, fail3}), 16'd0);
  endtask

  typedef struct {
    logic [2:0] mode;
    logic       rst_first;
    logic [3:0] f1;
    logic [2:0] e1;
    logic       p1;
    logic [3:0] f3;
    logic [2:0] e3;
    logic       p3;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t1, t3;
    logic [2:0] st1;

    tbl[0] = '{3'd0, 1'b0, 4'b0000, 3'd0, 1'b1, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{3'd1, 1'b0, 4'b0111, 3'd3, 1'b0, 4'b0111, 3'd3, 1'b0};
    tbl[2] = '{3'd2, 1'b0, 4'b1111, 3'd4, 1'b0, 4'b1111, 3'd4, 1'b0};
    tbl[3] = '{3'd3, 1'b1, 4'b1000, 3'd1, 1'b0, 4'b0000, 3'd0, 1'b1};
    tbl[4] = '{3'd4, 1'b0, 4'b0111, 3'd3, 1'b0, 4'b0111, 3'd3, 1'b0};
    tbl[5] = '{3'd5, 1'b0, 4'b1000, 3'd1, 1'b0, 4'b1000, 3'd1, 1'b0};
    tbl[6] = '{3'd6, 1'b0, 4'b1111, 3'd4, 1'b0, 4'b1111, 3'd4, 1'b0};
    tbl[7] = '{3'd7, 1'b0, 4'b1000, 3'd1, 1'b0, 4'b1000, 3'd1, 1'b0};

    do_reset();
    @(posedge clk); #1;
    chk_zero("reset");

    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      if (tbl[i].rst_first) do_reset();
      run(0, t1, t3, st1);
      chk($sformatf("v%0d_t1", i), 16'(t1), 16'd13);
      chk($sformatf("v%0d_t3", i), 16'(t3), 16'd21);
      chk($sformatf("v%0d_first", i), 16'(st1), 16'(3'b100));
      chk($sformatf("v%0d_res1", i), 16'({busy1, done1, pass1, err1, fail1}),
          16'({1'b0, 1'b1, tbl[i].p1, tbl[i].e1, tbl[i].f1}));
      chk($sformatf("v%0d_res3", i), 16'({busy3, done3, pass3, err3, fail3}),
          16'({1'b0, 1'b1, tbl[i].p3, tbl[i].e3, tbl[i].f3}));
      chk($sformatf("v%0d_drv", i), 16'({drv_a1, drv_b1, drv_a3, drv_b3}), 16'hF);
`ifdef GATE_CHK_LOG_EN
      if (tbl[i].mode == 3'd0) begin
        chk($sformatf("v%0d_log1", i), 16'(log1), 16'h95);
        chk($sformatf("v%0d_log3", i), 16'(log3), 16'h95);
      end
`endif
    end

    // start pulsed mid-run (during vector 1 of dut1) must be ignored.
    mode = 3'd0;
    run(4, t1, t3, st1);
    chk("busy_start_t1", 16'(t1), 16'd13);
    chk("busy_start_t3", 16'(t3), 16'd21);
    chk("busy_start_res", 16'({pass1, err1, fail1, pass3, err3, fail3}),
        16'({1'b1, 3'd0, 4'd0, 1'b1, 3'd0, 4'd0}));

    // Reset for one cycle during vector 2 discards the run.
    mode = 3'd2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_zero("midreset");
    repeat (25) @(posedge clk);
    #1;
    chk_zero("midreset_idle");
    mode = 3'd0;
    run(0, t1, t3, st1);
    chk("after_reset_t1", 16'(t1), 16'd13);
    chk("after_reset_res", 16'({pass1, err1, fail1, pass3, err3, fail3}),
        16'({1'b1, 3'd0, 4'd0, 1'b1, 3'd0, 4'd0}));

    // start held high: dut1 runs back to back, done visible for one cycle.
    do_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk); #1;
      if (c == 12) chk("held_c12", 16'({busy1, done1}), 16'(2'b10));
      if (c == 13) begin
        chk("held_c13", 16'({busy1, done1, pass1, err1, fail1}), 16'({3'b011, 3'd0, 4'd0}));
`ifdef GATE_CHK_LOG_EN
        chk("held_log_a", 16'(log1), 16'h95);
`endif
      end
      if (c == 14) chk("held_c14", 16'({busy1, done1, pass1}), 16'(3'b100));
      if (c == 27) begin
        chk("held_c27", 16'({busy1, done1, pass1, err1, fail1}), 16'({3'b011, 3'd0, 4'd0}));
`ifdef GATE_CHK_LOG_EN
        chk("held_log_b", 16'(log1), 16'h95);
`endif
      end
    end
    start = 1'b0;
    repeat (30) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
